// File: rtl/pb_seq_conditioner.sv
// pb_seq_conditioner: synchronise and debounce the two sequence-select keys
// and turn them into single-cycle step pulses with optional auto-repeat.
module pb_seq_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic key_up_n,
  input  logic key_dn_n,
  input  logic repeat_en,
  output logic pb_seq_up,
  output logic pb_seq_dn,
  output logic pb_locked
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] T_RATE  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_UP,
    HOLD_DN,
    LOCKOUT
  } state_e;

  // bit 0 = up key, bit 1 = down key; press/db are 1 when pressed
  logic [1:0]            meta_q, sync_q;
  logic [1:0]            press;
  logic [1:0]            db_q, db_d;
  logic [1:0]            dbp_q;
  logic [1:0]            rise;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             lock_q;

  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
    end else begin
      meta_q <= {key_dn_n, key_up_n};
      sync_q <= meta_q;
    end
  end

  assign press = ~sync_q;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (press[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + T_ONE;
        end
      end
    end
  end

  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      db_q  <= 2'b00;
      dbp_q <= 2'b00;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      dbp_q <= db_q;
      cnt_q <= cnt_d;
    end
  end

  assign rise = db_q & ~dbp_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((rise[0] && db_q[1]) || (rise[1] && db_q[0])) begin
          state_d = LOCKOUT;
        end else if (rise[0]) begin
          up_d    = 1'b1;
          tmr_d   = T_DELAY;
          state_d = HOLD_UP;
        end else if (rise[1]) begin
          dn_d    = 1'b1;
          tmr_d   = T_DELAY;
          state_d = HOLD_DN;
        end
      end
      HOLD_UP: begin
        if (db_q[1]) begin
          state_d = LOCKOUT;
        end else if (!db_q[0]) begin
          state_d = IDLE;
        end else if (repeat_en) begin
          if (tmr_q == T_ONE) begin
            up_d  = 1'b1;
            tmr_d = T_RATE;
          end else if (tmr_q != '0) begin
            tmr_d = tmr_q - T_ONE;
          end
        end
      end
      HOLD_DN: begin
        if (db_q[0]) begin
          state_d = LOCKOUT;
        end else if (!db_q[1]) begin
          state_d = IDLE;
        end else if (repeat_en) begin
          if (tmr_q == T_ONE) begin
            dn_d  = 1'b1;
            tmr_d = T_RATE;
          end else if (tmr_q != '0) begin
            tmr_d = tmr_q - T_ONE;
          end
        end
      end
      LOCKOUT: begin
        // a key still held here must be re-pressed to step again
        if (db_q == 2'b00) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      lock_q  <= (state_d == LOCKOUT);
    end
  end

  assign pb_seq_up = up_q;
  assign pb_seq_dn = dn_q;
  assign pb_locked = lock_q;

endmodule

// File: tb/tb_pb_seq_conditioner.sv
// Bench for pb_seq_conditioner: vector table, corner-case sequences and
// random key activity against a cycle-level reference model.
module tb_pb_seq_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam int CW = 25;
  localparam int NV = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic up_n  = 1'b1;
  logic dn_n  = 1'b1;
  logic ren   = 1'b0;
  logic pup, pdn, plock;

  int checks = 0;
  int errors = 0;
  int cu = 0;
  int cd = 0;

  pb_seq_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (CW)
  ) dut (
    .CLK_50   (clk),
    .reset    (rst_n),
    .key_up_n (up_n),
    .key_dn_n (dn_n),
    .repeat_en(ren),
    .pb_seq_up(pup),
    .pb_seq_dn(pdn),
    .pb_locked(plock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic up_n;
    logic dn_n;
    logic ren;
    logic up;
    logic dn;
    logic lk;
  } vec_t;

  vec_t vec[NV];

  // reference model: 0 idle, 1 holding up, 2 holding down, 3 locked
  bit [1:0] m_meta, m_s, m_db, m_dbp;
  int       m_run[2];
  int       m_mode;
  int       m_e;
  bit       e_up, e_dn, e_lk;

  task automatic model_reset();
    m_meta = 2'b00;
    m_s    = 2'b00;
    m_db   = 2'b00;
    m_dbp  = 2'b00;
    m_run[0] = 0;
    m_run[1] = 0;
    m_mode = 0;
    m_e    = 0;
    e_up   = 0;
    e_dn   = 0;
    e_lk   = 0;
  endtask

  function automatic bit repeat_due(input int e);
    return (e == RD) || (e > RD && ((e - RD) % RR) == 0);
  endfunction

  task automatic model_step(input bit kup_n, input bit kdn_n, input bit r);
    bit r0, r1, nu, nd;
    int nm;
    r0 = m_db[0] && !m_dbp[0];
    r1 = m_db[1] && !m_dbp[1];
    nu = 0;
    nd = 0;
    nm = m_mode;
    case (m_mode)
      0: begin
        if ((r0 && m_db[1]) || (r1 && m_db[0])) nm = 3;
        else if (r0) begin nu = 1; m_e = 0; nm = 1; end
        else if (r1) begin nd = 1; m_e = 0; nm = 2; end
      end
      1: begin
        if (m_db[1]) nm = 3;
        else if (!m_db[0]) nm = 0;
        else if (r) begin m_e++; nu = repeat_due(m_e); end
      end
      2: begin
        if (m_db[0]) nm = 3;
        else if (!m_db[1]) nm = 0;
        else if (r) begin m_e++; nd = repeat_due(m_e); end
      end
      default: if (m_db == 2'b00) nm = 0;
    endcase
    m_mode = nm;
    e_up = nu;
    e_dn = nd;
    e_lk = (nm == 3);
    m_dbp = m_db;
    for (int i = 0; i < 2; i++) begin
      if (m_s[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_db[i] = !m_db[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s = m_meta;
    m_meta = {!kdn_n, !kup_n};
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(up_n, dn_n, ren);
    @(negedge clk);
    chk("model_up", pup, e_up);
    chk("model_dn", pdn, e_dn);
    chk("model_lock", plock, e_lk);
    chk("up_dn_exclusive", pup & pdn, 1'b0);
    if (pup) cu++;
    if (pdn) cd++;
  endtask

  task automatic rtick();
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("reset_up", pup, 1'b0);
    chk("reset_dn", pdn, 1'b0);
    chk("reset_lock", plock, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int pos;
    bit ex;
    for (int i = 0; i < NV; i++) begin
      vec[i].up_n = (i < 10) ? 1'b0 : (i < 16) ? 1'b1 : 1'b0;
      vec[i].dn_n = (i < 16) ? 1'b1 : 1'b0;
      vec[i].ren  = 1'b0;
      vec[i].up   = (i == 6);
      vec[i].dn   = 1'b0;
      vec[i].lk   = (i >= 22);
    end

    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) rtick();
    rst_n = 1'b1;

    // clean press, release, then simultaneous press
    for (int i = 0; i < NV; i++) begin
      up_n = vec[i].up_n;
      dn_n = vec[i].dn_n;
      ren  = vec[i].ren;
      tick();
      chk($sformatf("vec%0d_up", i), pup, vec[i].up);
      chk($sformatf("vec%0d_dn", i), pdn, vec[i].dn);
      chk($sformatf("vec%0d_lock", i), plock, vec[i].lk);
    end

    up_n = 1'b1;
    dn_n = 1'b1;
    repeat (6) tick();
    chk("lock_exit_wait", plock, 1'b1);
    tick();
    chk("lock_exit", plock, 1'b0);

    // bounce on the down key, then a steady hold
    cd = 0;
    for (int i = 0; i < 20; i++) begin
      dn_n = ((i / 2) % 2) != 0;
      tick();
    end
    chk_int("bounce_quiet", cd, 0);
    dn_n = 1'b0;
    pos = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (pdn) pos = k;
    end
    chk_int("bounce_pulse_pos", pos, 7);
    chk_int("bounce_pulse_cnt", cd, 1);
    dn_n = 1'b1;
    repeat (8) tick();

    // long hold without repeat
    cu = 0;
    up_n = 1'b0;
    repeat (30) tick();
    chk_int("norepeat_cnt", cu, 1);
    up_n = 1'b1;
    repeat (8) tick();

    // auto-repeat cadence
    ren = 1'b1;
    up_n = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      ex = (k == 7) || (k >= 17 && ((k - 17) % 3) == 0);
      chk($sformatf("repeat_t%0d", k), pup, ex);
    end
    up_n = 1'b1;
    repeat (6) tick();
    cu = 0;
    repeat (10) tick();
    chk_int("repeat_after_release", cu, 0);

    // lockout entered from HOLD_UP
    up_n = 1'b0;
    repeat (12) tick();
    dn_n = 1'b0;
    repeat (6) tick();
    chk("hold_lock_pre", plock, 1'b0);
    tick();
    chk("hold_lock", plock, 1'b1);
    cu = 0;
    cd = 0;
    repeat (10) tick();
    chk_int("locked_no_pulse", cu + cd, 0);
    dn_n = 1'b1;
    repeat (15) tick();
    chk("lock_dn_released", plock, 1'b1);
    chk_int("lock_dn_rel_no_pulse", cu + cd, 0);
    up_n = 1'b1;
    repeat (6) tick();
    chk("lock_both_wait", plock, 1'b1);
    tick();
    chk("lock_both_released", plock, 1'b0);
    ren = 1'b0;
    repeat (4) tick();

    // reset asserted while a pulse is on the output
    ren = 1'b1;
    up_n = 1'b0;
    repeat (7) tick();
    chk("rst_pre_pulse", pup, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_up", pup, 1'b0);
    chk("async_rst_dn", pdn, 1'b0);
    chk("async_rst_lock", plock, 1'b0);
    model_reset();
    repeat (2) rtick();
    rst_n = 1'b1;
    cu = 0;
    pos = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (pup) pos = k;
    end
    chk_int("rst_repress_pos", pos, 7);
    chk_int("rst_repress_cnt", cu, 1);
    ren = 1'b0;
    up_n = 1'b1;
    repeat (8) tick();

    // random key activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) up_n = ~up_n;
      if ($urandom_range(7) == 0) dn_n = ~dn_n;
      if ($urandom_range(49) == 0) ren = ~ren;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
